serial_adder: RTL

Bit-serial adder built around the existing `full_adder` cell. It performs a WIDTH-bit addition over WIDTH clock cycles, one bit per cycle, LSB first. Each `full_adder` carry output is registered and fed back into the cell's carry input on the next cycle. It is the sequential stage directly downstream of `full_adder`: it consumes the cell's `s`/`cout` outputs and exposes a start/done handshake to the surrounding datapath.

---
 rtl/serial_adder_pkg.sv | 30 +++
 rtl/serial_adder_full_adder.sv | 24 ++
 rtl/serial_adder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder and anything that observes it:
//   the FSM state encodings, the default operand width and the helper that
//   sizes the bit counter.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  // Default operand / sum width in bits.
  localparam int SA_WIDTH_DEFAULT = 8;

  // FSM state encodings. They appear on the debug state port, so external
  // checkers can compare against these constants directly.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Width of the bit counter: enough to hold 0..width-1. The counter never
  // needs to represent width itself, because the terminal compare is against
  // width-1. The result is clamped to 1 so that the vector stays legal.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell. This is the bit slice that the serial adder
//   reuses on every cycle.
//
//   Ports (the cell's existing port order):
//     s    out  sum bit      x ^ y ^ cin
//     cout out  carry out    majority(x, y, cin)
//     x    in   operand bit A
//     y    in   operand bit B
//     cin  in   carry in
// -----------------------------------------------------------------------------
module full_adder (
  output logic s,
  output logic cout,
  input  logic x,
  input  logic y,
  input  logic cin
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder. It adds two WIDTH-bit operands plus a carry-in over
//   WIDTH clock cycles, one bit per cycle, LSB first. A single full_adder cell
//   handles every bit. Its carry is registered and fed back into the cell on
//   the next cycle.
//
//   Handshake:
//     start is sampled only in IDLE or DONE. On the edge that accepts it,
//     a, b and cin are captured, so later changes to those inputs have no
//     effect. busy is high for exactly WIDTH cycles (SHIFT state). done is
//     then high for one cycle (DONE state), and on that same edge sum/cout
//     are updated. Holding start high during DONE launches the next operation
//     without first returning to IDLE. A start that arrives during SHIFT is
//     ignored. busy, done and state are decoded from the state register only.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   asynchronous active-high reset
//     start  in   operation request
//     a      in   operand A      [WIDTH-1:0]
//     b      in   operand B      [WIDTH-1:0]
//     cin    in   initial carry
//     busy   out  bits being processed
//     done   out  one-cycle result pulse
//     sum    out  registered sum [WIDTH-1:0], held until the next completion
//     cout   out  registered final carry, held with sum
//     state  out  current FSM state (debug observation)
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sr_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;

  // Bit slice: the current LSBs of both operand shifters plus the fed-back carry.
  full_adder u_fa (
    .s    (fa_s),
    .cout (fa_cout),
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .cin  (carry_q)
  );

  // The new sum bit enters at the MSB. After WIDTH shifts, the first (LSB)
  // sum bit has reached bit 0. On the final cycle the output register takes
  // this value, so the current bit is included.
  assign sr_next  = {fa_s, sr_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_SHIFT;
            sa_q    <= a;
            sb_q    <= b;
            sr_q    <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          sr_q    <= sr_next;
          carry_q <= fa_cout;
          if (last_bit) begin
            // Leave the counter at WIDTH-1 so that it never wraps inside SHIFT.
            state_q <= ST_DONE;
            sum_q   <= sr_next;
            cout_q  <= fa_cout;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          // The unused encoding recovers to IDLE without touching the results.
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign state = state_q;

endmodule
